// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader state encoding and default RAM geometry.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int CPU_ADDR_W = 4;
    localparam int CPU_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } loader_state_t;

    // The core is out of reset only while running or parked after a halt.
    function automatic logic core_live(input loader_state_t s);
        return (s == RUN) || (s == HALTED);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: registered previous value and a one-cycle pulse on 0->1.
// Latency: pulse is high for the one cycle after the edge that first samples d=1.
// Backpressure: none; a held input produces a single pulse.
module rise_detect (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic pulse
);

    logic prev_q,  prev_d;
    logic pulse_q, pulse_d;

    // Next values: remember the input, flag a 0->1 transition.
    always_comb begin
        prev_d  = d;
        pulse_d = d & ~prev_q;
    end

    // Edge-detect registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/program_loader.sv
// Program loader: streams a 2^ADDR_W-byte program into RAM with the core held in reset, then paces ctrl_en (optional LOADER_CHECKSUM_EN adds a byte checksum output).
// Latency: state changes one cycle after the sampling edge; ctrl_en is combinational from the tick and cpu_halt.
// Backpressure: in_ready is high for the whole LOAD state (1 byte/cycle), low otherwise.
module program_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = CPU_ADDR_W,
    parameter int DATA_W  = CPU_DATA_W,
    parameter int RUN_DIV = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load_start,
    input  logic              run_go,
    input  logic              run_mode,
    input  logic              step,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              cpu_halt,
    input  logic [ADDR_W-1:0] cpu_ram_addr,
    input  logic [DATA_W-1:0] cpu_ram_wdata,
    input  logic              cpu_ramWEN,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    output logic              cpu_nRST,
    output logic              ctrl_en,
    output logic              loaded,
    output logic [1:0]        state
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int                DIV_W     = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(RUN_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              loaded_q, loaded_d;
    logic              cpu_nrst_q, cpu_nrst_d;

    logic handshake;
    logic load_begin;
    logic step_pulse;
    logic tick;

    // Step button edges become single-cycle ticks for single-step mode.
    rise_detect u_step_rise (
        .clk   (CLK),
        .nrst  (nRST),
        .d     (step),
        .pulse (step_pulse)
    );

    assign in_ready  = (state_q == LOAD);
    assign handshake = in_valid & in_ready;

    // Next-state logic: load sequencing, run start and halt capture.
    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        loaded_d    = loaded_q;
        load_begin  = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d     = LOAD;
                    load_addr_d = '0;
                    loaded_d    = 1'b0;
                    load_begin  = 1'b1;
                end else if (run_go && loaded_q) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                // No abort path: only reset leaves LOAD early.
                if (handshake) begin
                    load_addr_d = load_addr_q + ADDR_W'(1);
                    if (load_addr_q == LAST_ADDR) begin
                        state_d  = IDLE;
                        loaded_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cpu_halt) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                // run_go is deliberately ignored; a fresh load is the only way out.
                if (load_start) begin
                    state_d     = LOAD;
                    load_addr_d = '0;
                    loaded_d    = 1'b0;
                    load_begin  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Divider advances only while free-running; it sits at 0 outside RUN so entry starts from 0.
    always_comb begin
        div_cnt_d = '0;
        if ((state_q == RUN) && run_mode) begin
            div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
        end
    end

    // Core reset is registered from the next state so it releases together with RUN entry.
    always_comb begin
        cpu_nrst_d = core_live(state_d);
    end

    // Step enable: choose tick source, gate by RUN and mask with a same-cycle halt.
    always_comb begin
        tick    = run_mode ? (div_cnt_q == DIV_LAST) : step_pulse;
        ctrl_en = (state_q == RUN) & tick & ~cpu_halt;
    end

    // RAM port mux: loader owns it in LOAD, the core writes only while running.
    always_comb begin
        ram_addr  = cpu_ram_addr;
        ram_wdata = cpu_ram_wdata;
        ram_wen   = (state_q == RUN) & cpu_ramWEN;
        if (state_q == LOAD) begin
            ram_addr  = load_addr_q;
            ram_wdata = in_data;
            ram_wen   = handshake;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= IDLE;
            load_addr_q <= '0;
            div_cnt_q   <= '0;
            loaded_q    <= 1'b0;
            cpu_nrst_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            div_cnt_q   <= div_cnt_d;
            loaded_q    <= loaded_d;
            cpu_nrst_q  <= cpu_nrst_d;
        end
    end

    assign cpu_nRST = cpu_nrst_q;
    assign loaded   = loaded_q;
    assign state    = state_q;

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_q, checksum_d;

    // Running byte sum of the current load; restarts on load entry and holds afterwards.
    always_comb begin
        checksum_d = checksum_q;
        if (load_begin) begin
            checksum_d = '0;
        end else if (handshake) begin
            checksum_d = checksum_q + in_data;
        end
    end

    // Checksum register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    logic unused_load_begin;
    assign unused_load_begin = load_begin;
`endif

endmodule

// File: doc/program_loader.md
# program_loader

Front-end sequencer that owns the CPU's 16x8 RAM write port and its step enable. It loads a program from a valid/ready byte stream into RAM while holding the CPU core in reset, then releases the core and paces its `ctrl_en` from one of two sources: a free-running divider or single-step pulses. It stops pacing when the core raises `halt`. It sits between the board I/O and the CPU top, multiplexing RAM access between itself and the core.

## Interface
Parameters:
- ADDR_W, 4, RAM address width; one load = 2^ADDR_W bytes
- DATA_W, 8, RAM/bus data width
- RUN_DIV, 4, cycles per `ctrl_en` pulse in run mode (>=1)

Ports (one clock; reset is synchronous and active-low):
- CLK  in  1  system clock
- nRST  in  1  synchronous active-low reset
- load_start  in  1  level; begins a load from IDLE or HALTED
- run_go  in  1  level; starts execution from IDLE once a program is loaded
- run_mode  in  1  1 = free-run via divider, 0 = single-step
- step  in  1  step button, already debounced; rising edge = one step
- in_valid  in  1  stream byte valid
- in_data  in  DATA_W  stream byte
- in_ready  out  1  loader accepts a byte
- cpu_halt  in  1  `halt` from the control unit
- cpu_ram_addr  in  ADDR_W  core's RAM address
- cpu_ram_wdata  in  DATA_W  core's RAM write data
- cpu_ramWEN  in  1  core's RAM write enable
- ram_addr  out  ADDR_W  muxed RAM address
- ram_wdata  out  DATA_W  muxed RAM write data
- ram_wen  out  1  muxed RAM write enable
- cpu_nRST  out  1  registered reset to the core, active-low
- ctrl_en  out  1  step enable to the control unit
- loaded  out  1  a complete program is resident in RAM
- state  out  2  current state, for debug and LEDs

## Operation
States: IDLE=0, LOAD=1, RUN=2, HALTED=3.

- **IDLE**
  - `load_start` -> LOAD; this clears `load_addr` and `loaded`.
  - Otherwise `run_go & loaded` -> RUN.
  - `load_start` takes priority over `run_go`.
- **LOAD**
  - `in_ready`=1.
  - Each handshake (`in_valid & in_ready`) writes `in_data` to `load_addr`, then increments `load_addr`.
  - The handshake at `load_addr` = 2^ADDR_W-1 causes `load_addr` to wrap to 0, the state to go to IDLE and `loaded` to set.
  - `load_start` and `run_go` are ignored in LOAD. There is no abort; only `nRST` aborts.
- **RUN**
  - `cpu_nRST`=1.
  - `ctrl_en` = `tick & ~cpu_halt`.
  - `cpu_halt` -> HALTED.
- **HALTED**
  - `ctrl_en`=0 and `cpu_nRST` stays 1, so core state remains visible.
  - `load_start` -> LOAD.
  - `run_go` is ignored.

Tick sources:
- run_mode=1: `div_cnt` counts 0..RUN_DIV-1 and `tick` is high when `div_cnt`=RUN_DIV-1. With RUN_DIV=1, `tick` is high every cycle.
- run_mode=0: `div_cnt` is held at 0. `tick` is high for exactly one cycle per rising edge of `step`; a held `step` yields a single pulse.
- `div_cnt` clears on RUN entry and whenever run_mode=0.

RAM mux:
- In LOAD: `ram_addr`=`load_addr`, `ram_wdata`=`in_data`, `ram_wen`=handshake.
- Otherwise: the core's address and data pass through. `ram_wen` = `cpu_ramWEN` only in RUN and is 0 elsewhere.

`cpu_nRST` is 0 in IDLE (after reset), in LOAD and in the cycle leaving LOAD.

## Timing
- Reset values: state=IDLE, `load_addr`=0, `div_cnt`=0, `loaded`=0, `cpu_nRST`=0, `in_ready`=0, `ctrl_en`=0, `ram_wen`=0. `ram_addr`/`ram_wdata` follow the core inputs.
- `load_start` sampled high at edge n -> LOAD and `in_ready`=1 from cycle n+1.
- Maximum load throughput is 1 byte/cycle; 16 bytes take 16 cycles.
- Last handshake at edge m -> IDLE and `loaded`=1 from m+1.
- `run_go` at edge r -> RUN from r+1, `cpu_nRST`=1 from r+1. The first `ctrl_en` is at cycle r+RUN_DIV in run mode; it is never in the entry cycle when RUN_DIV>1.
- `step` rising edge sampled at edge s -> `ctrl_en` high during cycle s+1 only.
- `cpu_halt` is combinational from the core. `ctrl_en` is masked in the same cycle, and the state is HALTED the next cycle.
- Simultaneous `tick` and `cpu_halt`: no pulse.
- Synchronous reset mid-LOAD: the partial program is abandoned and `loaded`=0. RAM contents are undefined-but-unchanged.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Adds output `checksum[DATA_W-1:0]`, the modulo-2^DATA_W sum of the bytes accepted in the current load.
  - Clears on LOAD entry and on reset.
  - Holds its value after the load.
- Not defined: no port and no adder.

## Structure
- `cpu_pkg` holds the `loader_state_t` enum (IDLE/LOAD/RUN/HALTED, 2 bits) and the default ADDR_W/DATA_W constants shared with the control unit and RAM.
- One sub-module, `rise_detect`: a registered previous value plus a one-cycle pulse on 0->1. It is used for `step`.

## Test plan
- **Reset:** `nRST`=0 for 2 cycles -> all outputs at their reset values and state=0.
- **Load:** `load_start` pulse, then 16 bytes 0x10..0x1F with `in_valid` toggling every other cycle -> RAM[i]=0x10+i, `loaded`=1 after the 16th handshake, state back to IDLE. With LOADER_CHECKSUM_EN defined, `checksum`=0x78.
- **Free-run:** RUN_DIV=4, `run_go` with run_mode=1 -> `ctrl_en` high 1 cycle in 4, first pulse 4 cycles after RUN entry. Force `cpu_halt`=1 on a tick cycle -> no pulse and state=HALTED next cycle.
- **Single-step:** run_mode=0, `step` held high for 10 cycles, then low, then high again -> exactly 2 `ctrl_en` pulses.
- **Reload while halted:** from HALTED assert `load_start` -> `cpu_nRST`=0 next cycle, core RAM writes blocked, new program loaded.
- **Mid-load reset:** `nRST` low after 7 bytes -> state=IDLE, `loaded`=0, `run_go` ignored until a full reload completes.
